// File: rtl/button_event.sv
// Turns a debounced button level into single-cycle press / release /
// long-press events; auto-repeat in LONG is built when BUTTON_REPEAT_EN is defined.
module button_event #(
   parameter int unsigned CLK_PERIOD_ns = 20,
   parameter int unsigned LONG_PRESS_ns = 1_000_000_000,
   parameter int unsigned REPEAT_ns     = 200_000_000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       enable,
   input  logic       sig_i,
   output logic       held,
   output logic       press,
   output logic       release_evt,
   output logic       long_press,
   output logic       repeat_evt,
   output logic [7:0] press_count
);

   localparam int unsigned LONG_CYCLES   = LONG_PRESS_ns / CLK_PERIOD_ns;
   localparam int unsigned REPEAT_CYCLES = REPEAT_ns / CLK_PERIOD_ns;
   localparam int unsigned MAX_CYCLES    =
      (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES);

   // Counter value on the edge where the hold reaches LONG_CYCLES.
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

   if (LONG_CYCLES < 2) begin : g_long_chk
      $error("button_event: LONG_CYCLES must be >= 2");
   end

   if (REPEAT_CYCLES < 2) begin : g_rep_chk
      $error("button_event: REPEAT_CYCLES must be >= 2");
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESSED,
      ST_LONG
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   // High until the first enabled edge after reset.
   logic          post_rst;
   // Current hold began before reset exit: it produces no events.
   logic          stale_hold;

`ifdef BUTTON_REPEAT_EN
   localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
   logic rep_q;

   assign repeat_evt = rep_q;
`else
   assign repeat_evt = 1'b0;
`endif

   // Button FSM: hold timing, registered event pulses and press counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         post_rst    <= 1'b1;
         stale_hold  <= 1'b0;
         held        <= 1'b0;
         press       <= 1'b0;
         release_evt <= 1'b0;
         long_press  <= 1'b0;
         press_count <= 8'd0;
`ifdef BUTTON_REPEAT_EN
         rep_q       <= 1'b0;
`endif
      end else if (!enable) begin
         press       <= 1'b0;
         release_evt <= 1'b0;
         long_press  <= 1'b0;
`ifdef BUTTON_REPEAT_EN
         rep_q       <= 1'b0;
`endif
      end else begin
         press       <= 1'b0;
         release_evt <= 1'b0;
         long_press  <= 1'b0;
`ifdef BUTTON_REPEAT_EN
         rep_q       <= 1'b0;
`endif
         post_rst    <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (sig_i) begin
                  state      <= ST_PRESSED;
                  held       <= 1'b1;
                  cnt        <= '0;
                  stale_hold <= post_rst;
                  if (!post_rst) begin
                     press       <= 1'b1;
                     press_count <= press_count + 8'd1;
                  end
               end
            end
            ST_PRESSED: begin
               if (!sig_i) begin
                  state       <= ST_IDLE;
                  held        <= 1'b0;
                  stale_hold  <= 1'b0;
                  release_evt <= !stale_hold;
               end else if (cnt == LONG_LAST) begin
                  state      <= ST_LONG;
                  cnt        <= '0;
                  long_press <= !stale_hold;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_LONG: begin
               if (!sig_i) begin
                  state       <= ST_IDLE;
                  held        <= 1'b0;
                  stale_hold  <= 1'b0;
                  release_evt <= !stale_hold;
`ifdef BUTTON_REPEAT_EN
               end else if (cnt == REP_LAST) begin
                  cnt   <= '0;
                  rep_q <= !stale_hold;
               end else begin
                  cnt <= cnt + CW'(1);
`endif
               end
            end
            default: begin
               state <= ST_IDLE;
               held  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event.sv
// Randomized and directed bench for button_event against a hold-age model.
module tb_button_event;

   localparam int L = 10;
   localparam int R = 5;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b1;
   logic       sig_i = 1'b0;
   logic       held;
   logic       press;
   logic       release_evt;
   logic       long_press;
   logic       repeat_evt;
   logic [7:0] press_count;

   button_event #(
      .CLK_PERIOD_ns(20),
      .LONG_PRESS_ns(200),
      .REPEAT_ns(100)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .enable(enable),
      .sig_i(sig_i),
      .held(held),
      .press(press),
      .release_evt(release_evt),
      .long_press(long_press),
      .repeat_evt(repeat_evt),
      .press_count(press_count)
   );

   always #10 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // model state: level, hold age in enabled edges, count
   bit m_first = 1'b1;
   bit m_held = 1'b0;
   bit m_ghost = 1'b0;
   int m_age = 0;
   int m_count = 0;
   bit e_press, e_rel, e_long, e_rep;

   // observed DUT events
   int press_cyc = -1;
   int rel_cyc = -1;
   int long_cyc = -1;
   int press_n = 0;
   int rel_n = 0;
   int long_n = 0;
   int rep_n = 0;
   int rep_q[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      e_press = 1'b0;
      e_rel = 1'b0;
      e_long = 1'b0;
      e_rep = 1'b0;
      if (!resetn) begin
         m_first = 1'b1;
         m_held = 1'b0;
         m_ghost = 1'b0;
         m_age = 0;
         m_count = 0;
      end else if (enable) begin
         if (!m_held) begin
            if (sig_i) begin
               m_held = 1'b1;
               m_ghost = m_first;
               m_age = 0;
               if (!m_first) begin
                  e_press = 1'b1;
                  m_count = (m_count + 1) % 256;
               end
            end
         end else if (!sig_i) begin
            e_rel = !m_ghost;
            m_held = 1'b0;
         end else begin
            m_age++;
            if (m_age == L) e_long = !m_ghost;
`ifdef BUTTON_REPEAT_EN
            if (m_age > L && (m_age - L) % R == 0) e_rep = !m_ghost;
`endif
         end
         m_first = 1'b0;
      end
   endtask

   // per-cycle comparison against the model
   always @(posedge clk) begin
      int act, exp;
      model_step();
      cyc++;
      #1;
      act = {19'd0, held, press, release_evt, long_press, repeat_evt,
             press_count};
      exp = {19'd0, m_held, e_press, e_rel, e_long, e_rep, 8'(m_count)};
      chk("outputs", act, exp);
      if (press) begin press_cyc = cyc; press_n++; end
      if (release_evt) begin rel_cyc = cyc; rel_n++; end
      if (long_press) begin long_cyc = cyc; long_n++; end
      if (repeat_evt) begin rep_n++; rep_q.push_back(cyc); end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n0, l0, r0, len;
      // reset exit with the button already held
      resetn = 1'b0;
      sig_i = 1'b1;
      step(2);
      resetn = 1'b1;
      @(posedge clk);
      #2;
      chk("held_after_reset", int'(held), 1);
      chk("no_press_after_reset", int'(press), 0);
      step(15);
      sig_i = 1'b0;
      step(3);
      chk("stale_no_long", long_n, 0);
      chk("stale_no_release", rel_n, 0);
      chk("stale_no_press", press_n, 0);
      chk("stale_count", int'(press_count), 0);

      // short press
      sig_i = 1'b1;
      step(4);
      sig_i = 1'b0;
      step(3);
      chk("short_count", int'(press_count), 1);
      chk("model_count", m_count, 1);
      chk("short_rel_offset", rel_cyc - press_cyc, 4);
      chk("short_no_long", long_n, 0);

      // long hold
      rep_q.delete();
      l0 = long_n;
      r0 = rep_n;
      sig_i = 1'b1;
      step(30);
      sig_i = 1'b0;
      step(3);
      chk("long_once", long_n - l0, 1);
      chk("long_offset", long_cyc - press_cyc, 10);
`ifdef BUTTON_REPEAT_EN
      chk("rep_num", rep_q.size(), 3);
      if (rep_q.size() == 3) begin
         chk("rep1", rep_q[0] - long_cyc, 5);
         chk("rep2", rep_q[1] - long_cyc, 10);
         chk("rep3", rep_q[2] - long_cyc, 15);
      end
`else
      chk("rep_none", rep_n - r0, 0);
`endif

      // release on the threshold edge
      l0 = long_n;
      sig_i = 1'b1;
      step(10);
      sig_i = 1'b0;
      step(3);
      chk("thresh_no_long", long_n - l0, 0);
      chk("thresh_rel_offset", rel_cyc - press_cyc, 10);

      // enable gap mid-hold
      sig_i = 1'b1;
      step(4);
      enable = 1'b0;
      step(3);
      enable = 1'b1;
      step(16);
      sig_i = 1'b0;
      step(3);
      chk("gap_long_offset", long_cyc - press_cyc, 13);

      // randomized runs
      repeat (60) begin
         sig_i = ~sig_i;
         len = sig_i ? $urandom_range(1, 28) : $urandom_range(2, 8);
         repeat (len) begin
            enable = ($urandom_range(0, 9) != 0);
            resetn = ($urandom_range(0, 199) != 0);
            step(1);
         end
      end
      enable = 1'b1;
      resetn = 1'b1;
      sig_i = 1'b0;
      step(3);

      // press_count wrap
      resetn = 1'b0;
      step(1);
      resetn = 1'b1;
      step(1);
      repeat (255) begin
         sig_i = 1'b1;
         step(1);
         sig_i = 1'b0;
         step(2);
      end
      chk("count_255", int'(press_count), 255);
      sig_i = 1'b1;
      step(1);
      sig_i = 1'b0;
      step(2);
      chk("count_wrap", int'(press_count), 0);

      // asynchronous reset mid-hold
      sig_i = 1'b1;
      step(5);
      chk("pre_reset_count", int'(press_count), 1);
      resetn = 1'b0;
      #1;
      chk("async_rst_outs",
          {26'd0, held, press, release_evt, long_press, repeat_evt, 1'b0}, 0);
      chk("async_rst_count", int'(press_count), 0);
      step(2);
      resetn = 1'b1;
      n0 = press_n;
      r0 = rel_n;
      step(5);
      chk("rst_hold_no_press", press_n - n0, 0);
      sig_i = 1'b0;
      step(2);
      chk("rst_hold_no_rel", rel_n - r0, 0);
      sig_i = 1'b1;
      step(2);
      chk("rst_then_press", int'(press_count), 1);
      sig_i = 1'b0;
      step(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
